// File: rtl/maze_room_renderer.sv
`default_nettype none
// ============================================================================
// Module   : maze_room_renderer
// Brief    : VGA timing, writable room map, wall pixel and sprite collision for
//            the current room, with room changes committed at frame end.
// Revision : 1.0 - initial release
// ============================================================================
module maze_room_renderer #(
  parameter int         H_ACTIVE   = 640,
  parameter int         H_FP       = 16,
  parameter int         H_SYNC     = 96,
  parameter int         H_BP       = 48,
  parameter int         V_ACTIVE   = 480,
  parameter int         V_FP       = 10,
  parameter int         V_SYNC     = 2,
  parameter int         V_BP       = 33,
  parameter int         WALL       = 100,
  parameter int         SPRITE     = 16,
  parameter int         GRID_W     = 3,
  parameter int         GRID_H     = 3,
  parameter int         START_X    = 0,
  parameter int         START_Y    = 0,
  parameter logic [3:0] RESET_MASK = 4'hF
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       map_we,
  input  logic [5:0] map_addr,
  input  logic [3:0] map_data,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic       move_req,
  input  logic [1:0] move_dir,
  output logic       move_ack,
  output logic       move_ok,
  output logic [2:0] room_x,
  output logic [2:0] room_y,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       wall_px,
  output logic       collision,
  output logic       frame_start
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_CELLS   = GRID_W * GRID_H;
  localparam int c_IW      = (c_CELLS > 1) ? $clog2(c_CELLS) : 1;

  localparam logic [10:0] c_H_LAST = 11'(c_H_TOTAL - 1);
  localparam logic [10:0] c_V_LAST = 11'(c_V_TOTAL - 1);
  localparam logic [10:0] c_HA     = 11'(H_ACTIVE);
  localparam logic [10:0] c_VA     = 11'(V_ACTIVE);
  localparam logic [10:0] c_HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] c_WALL   = 11'(WALL);
  localparam logic [10:0] c_E_EDGE = 11'(H_ACTIVE - WALL);
  localparam logic [10:0] c_S_EDGE = 11'(V_ACTIVE - WALL);
  localparam logic [10:0] c_SPR_M1 = 11'(SPRITE - 1);
  localparam logic [2:0]  c_COL_LAST = 3'(GRID_W - 1);
  localparam logic [2:0]  c_ROW_LAST = 3'(GRID_H - 1);
  localparam logic [6:0]  c_CELLS_W  = 7'(c_CELLS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [10:0]     r_h;
  logic [10:0]     r_v;
  logic [3:0]      r_map [c_CELLS];
  logic [2:0]      r_room_x;
  logic [2:0]      r_room_y;
  logic [1:0]      r_dir;
  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_move_ack;
  logic            r_move_ok;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_de;
  logic [9:0]      r_px_x;
  logic [9:0]      r_px_y;
  logic            r_wall_px;
  logic            r_collision;
  logic            r_frame_start;

  logic            w_frame_end;
  logic            w_active;
  logic            w_in_n, w_in_s, w_in_w, w_in_e;
  logic            w_wall;
  logic [c_IW-1:0] w_room_idx;
  logic [3:0]      w_mask;
  logic [10:0]     w_pl_x0, w_pl_x1, w_pl_y0, w_pl_y1;
  logic            w_ov_w, w_ov_e, w_ov_mx, w_ov_n, w_ov_s, w_ov_my;
  logic            w_collide;
  logic            w_blocked;
  logic            w_dir_load;
  logic            w_commit;
  logic            w_ack_nxt;
  logic            w_ok_nxt;

  // Raster counters
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == c_H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == c_V_LAST) ? '0 : r_v + 11'd1;
    end else begin
      r_h <= r_h + 11'd1;
    end
  end

  assign w_frame_end = (r_h == c_H_LAST) && (r_v == c_V_LAST);
  assign w_active    = (r_h < c_HA) && (r_v < c_VA);

  // Room map
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_CELLS; i++) begin
        r_map[i] <= RESET_MASK;
      end
    end else if (map_we && ({1'b0, map_addr} < c_CELLS_W)) begin
      r_map[map_addr[c_IW-1:0]] <= map_data;
    end
  end

  assign w_room_idx = c_IW'(r_room_y) * c_IW'(GRID_W) + c_IW'(r_room_x);
  assign w_mask     = r_map[w_room_idx];

  // Wall geometry for the current raster position; mask is {N,E,S,W}
  assign w_in_n = (r_v < c_WALL);
  assign w_in_s = (r_v >= c_S_EDGE);
  assign w_in_w = (r_h < c_WALL);
  assign w_in_e = (r_h >= c_E_EDGE);
  assign w_wall = w_active &&
                  (((w_in_n || w_in_s) && (w_in_w || w_in_e)) ||
                   (w_in_n && !w_mask[3]) || (w_in_e && !w_mask[2]) ||
                   (w_in_s && !w_mask[1]) || (w_in_w && !w_mask[0]));

  // Sprite rectangle against the wall bands, per axis: W/E/middle, N/S/middle
  assign w_pl_x0 = {1'b0, player_x};
  assign w_pl_y0 = {1'b0, player_y};
  assign w_pl_x1 = w_pl_x0 + c_SPR_M1;
  assign w_pl_y1 = w_pl_y0 + c_SPR_M1;

  assign w_ov_w  = (w_pl_x0 < c_WALL);
  assign w_ov_e  = (w_pl_x1 >= c_E_EDGE) && (w_pl_x0 < c_HA);
  assign w_ov_mx = (w_pl_x0 < c_E_EDGE) && (w_pl_x1 >= c_WALL);
  assign w_ov_n  = (w_pl_y0 < c_WALL);
  assign w_ov_s  = (w_pl_y1 >= c_S_EDGE) && (w_pl_y0 < c_VA);
  assign w_ov_my = (w_pl_y0 < c_S_EDGE) && (w_pl_y1 >= c_WALL);

  assign w_collide = ((w_ov_w || w_ov_e) && (w_ov_n || w_ov_s)) ||
                     (!w_mask[3] && w_ov_n && w_ov_mx) ||
                     (!w_mask[1] && w_ov_s && w_ov_mx) ||
                     (!w_mask[0] && w_ov_w && w_ov_my) ||
                     (!w_mask[2] && w_ov_e && w_ov_my);

  // Pixel pipeline
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_de          <= 1'b0;
      r_px_x        <= '0;
      r_px_y        <= '0;
      r_wall_px     <= 1'b0;
      r_collision   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= !((r_h >= c_HS_BEG) && (r_h < c_HS_END));
      r_vsync       <= !((r_v >= c_VS_BEG) && (r_v < c_VS_END));
      r_de          <= w_active;
      r_px_x        <= r_h[9:0];
      r_px_y        <= r_v[9:0];
      r_wall_px     <= w_wall;
      r_collision   <= w_collide;
      r_frame_start <= (r_h == 11'd0) && (r_v == 11'd0);
    end
  end

  always_comb begin
    w_blocked = 1'b0;
    case (r_dir)
      2'd0:    w_blocked = (r_room_y == 3'd0)       || !w_mask[3];
      2'd1:    w_blocked = (r_room_x == c_COL_LAST) || !w_mask[2];
      2'd2:    w_blocked = (r_room_y == c_ROW_LAST) || !w_mask[1];
      default: w_blocked = (r_room_x == 3'd0)       || !w_mask[0];
    endcase
  end

  // Move handshake
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_load  = 1'b0;
    w_commit    = 1'b0;
    w_ack_nxt   = 1'b0;
    w_ok_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The ack cycle itself still sees the old request held high
        if (move_req && !r_move_ack) begin
          w_dir_load  = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_blocked) begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_frame_end) begin
          w_commit    = 1'b1;
          w_ack_nxt   = 1'b1;
          w_ok_nxt    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      r_room_x   <= 3'(START_X);
      r_room_y   <= 3'(START_Y);
      r_dir      <= 2'd0;
      r_move_ack <= 1'b0;
      r_move_ok  <= 1'b0;
    end else begin
      r_move_ack <= w_ack_nxt;
      r_move_ok  <= w_ok_nxt;
      if (w_dir_load) begin
        r_dir <= move_dir;
      end
      if (w_commit) begin
        case (r_dir)
          2'd0:    r_room_y <= r_room_y - 3'd1;
          2'd1:    r_room_x <= r_room_x + 3'd1;
          2'd2:    r_room_y <= r_room_y + 3'd1;
          default: r_room_x <= r_room_x - 3'd1;
        endcase
      end
    end
  end

  assign move_ack    = r_move_ack;
  assign move_ok     = r_move_ok;
  assign room_x      = r_room_x;
  assign room_y      = r_room_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign px_x        = r_px_x;
  assign px_y        = r_px_y;
  assign wall_px     = r_wall_px;
  assign collision   = r_collision;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: doc/maze_room_renderer.md
Name: maze_room_renderer

Overview:
Parametrised successor to the fixed 3x3 maze display. It generates the VGA timing, holds a writable GRID_W x GRID_H room map, and outputs the wall pixel and player-collision flag for the current room. Room changes use a request/acknowledge handshake and are committed only at frame end, so the picture never tears. It sits between the pixel-clock divider and the player/colour logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
WALL, 100, wall thickness in pixels
SPRITE, 16, player sprite size in pixels
GRID_W, 3, rooms per map row (1..8)
GRID_H, 3, room rows (1..8)
START_X, 0, room column after reset
START_Y, 0, room row after reset
RESET_MASK, 4'hF, door mask loaded into every map cell at reset

Ports:
CLOCK_25  in  1  pixel clock
reset  in  1  asynchronous, active-high
map_we  in  1  map write strobe
map_addr  in  6  cell index, row*GRID_W+col
map_data  in  4  door mask {N,E,S,W}; 1 = open
player_x  in  10  sprite top-left x, active coordinates
player_y  in  10  sprite top-left y
move_req  in  1  room-change request, held until move_ack
move_dir  in  2  0=N 1=E 2=S 3=W
move_ack  out  1  one-cycle response pulse
move_ok  out  1  valid with move_ack; 1 = move committed
room_x  out  3  current room column
room_y  out  3  current room row
hsync  out  1  active-low sync
vsync  out  1  active-low sync
de  out  1  display enable
px_x  out  10  pixel x, aligned with de
px_y  out  10  pixel y, aligned with de
wall_px  out  1  current pixel is wall (0 outside de)
collision  out  1  sprite overlaps wall
frame_start  out  1  one-cycle pulse on first active pixel (0,0)

Behaviour:
- Counters: h runs 0..H_TOTAL-1, then wraps and advances v; v runs 0..V_TOTAL-1. Order per axis: active, front porch, sync, back porch.
- All pixel outputs are registered with latency 1: outputs on cycle n+1 reflect counter values at cycle n.
- Reset values: counters 0, hsync=vsync=1, de=0, px_x=px_y=0, wall_px=0, collision=0, move_ack=0, move_ok=0, frame_start=0, room=(START_X,START_Y), every map cell = RESET_MASK.
- Room geometry for door mask m, at active pixel (x,y):
  - The four WALL x WALL corners are always wall.
  - Edge strips are wall when the door bit is 0: N strip y<WALL; S strip y>=V_ACTIVE-WALL; W strip x<WALL; E strip x>=H_ACTIVE-WALL (each excluding the corners).
  - Everything else is floor.
- Collision: registered, latency 1. Asserted when any wall pixel lies inside the rectangle [player_x, player_x+SPRITE-1] x [player_y, player_y+SPRITE-1]. Evaluate this with rectangle-overlap compares, not a pixel scan.
- Map writes take effect the next cycle. map_addr >= GRID_W*GRID_H is ignored. A write to the current room changes rendering mid-frame; this is allowed.
- Move FSM:
  - IDLE: on move_req, latch move_dir and go to CHECK.
  - CHECK (1 cycle): reject when the target is off-grid or the current room's door bit for move_dir is 0. Reject means move_ack=1, move_ok=0, back to IDLE.
  - Otherwise go to WAIT.
  - WAIT: on the cycle where h=H_TOTAL-1 and v=V_TOTAL-1, update room_x/room_y, pulse move_ack=1 with move_ok=1, and go to IDLE.
  - The first frame after the commit renders the new room.
- The requester must drop move_req on the cycle after move_ack. A move_req still high in IDLE the cycle after an ack starts a new request.
- move_dir changes during CHECK or WAIT are ignored.
- reset asserted mid-WAIT discards the pending move.
- Widths: compares are done in 11 bits so that x+SPRITE-1 cannot overflow.

Test Plan:
- Release reset, count cycles -> first frame_start at cycle 1, hsync low for 96 cycles starting at h=656, frame period 800*525=420000 cycles.
- Default map (all 4'hF), room (0,0), scan line y=50 -> wall_px high for x<100 and x>=540 only; line y=240 -> wall_px never high.
- Write mask 4'b0000 to cell 4, move from room (1,0) with dir=S -> ack with move_ok=1 at frame end, room_y=1, next frame shows wall across full N/S/E/W strips.
- Request dir=N in room (0,0) -> ack 2 cycles after move_req with move_ok=0; room unchanged.
- Player at (90,200) in a room with W door closed -> collision=1. Open the W door -> collision=0 one cycle after the write.
- Assert reset during WAIT -> no move_ack; room returns to (START_X,START_Y).
